// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and its iterative controller.
// The function codes are the board-level encoding used by the command registers.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

endpackage : alu_pkg

// File: rtl/alu.sv
// Combinational W-bit ALU shared by the board datapath and the sequencer.
// Arithmetic wraps modulo 2^W; codes outside the defined set yield zero.
module alu
  import alu_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  input  logic [ALU_OP_W-1:0] op,
  output logic [W-1:0]        y
);

  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule : alu

// File: rtl/alu_seq.sv
// Iterative controller: loads opa into the accumulator, then applies acc <= acc OP opb
// for n cycles, with a start/busy/done handshake around the shared alu.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W  = 6,
  parameter int CW = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [W-1:0]        opa,
  input  logic [W-1:0]        opb,
  input  logic [CW-1:0]       n,
  output logic                busy,
  output logic                done,
  output logic [W-1:0]        result,
  output logic                zero,
  output logic [CW-1:0]       iter
);

  seq_state_e          state;
  logic [ALU_OP_W-1:0] op_q;
  logic [W-1:0]        opb_q;
  logic [CW-1:0]       n_q;
  logic [W-1:0]        acc;
  logic [CW-1:0]       iter_q;
  logic                busy_q;
  logic                done_q;
  logic [W-1:0]        alu_y;

  alu #(
    .W(W)
  ) u_alu (
    .a (acc),
    .b (opb_q),
    .op(op_q),
    .y (alu_y)
  );

  // Only the latched command copies feed the datapath, so the upstream
  // registers are free to change once the start edge has been taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      op_q   <= '0;
      opb_q  <= '0;
      n_q    <= '0;
      acc    <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            opb_q  <= opb;
            n_q    <= n;
            acc    <= opa;
            iter_q <= '0;
            if (n == '0) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state  <= S_RUN;
              busy_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          acc    <= alu_y;
          iter_q <= iter_q + CW'(1);
          if (iter_q == n_q - CW'(1)) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = acc;
  assign zero   = (acc == '0);
  assign iter   = iter_q;

endmodule : alu_seq

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results are queued at start and
// compared when done pulses, along with handshake timing and reset behaviour.
module tb_alu_seq;

  localparam int W  = 6;
  localparam int CW = 4;

  typedef struct packed {
    logic [W-1:0]  res;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [CW-1:0] n;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          zero;
  logic [CW-1:0] iter;

  int   vectors;
  int   miscompares;
  exp_t sb[$];

  alu_seq #(
    .W (W),
    .CW(CW)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .op    (op),
    .opa   (opa),
    .opb   (opb),
    .n     (n),
    .busy  (busy),
    .done  (done),
    .result(result),
    .zero  (zero),
    .iter  (iter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_step(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [2:0] f);
    case (f)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one command, optionally injecting a stray start mid-run and in the done cycle.
  task automatic applyStimulus(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                               input int cnt, input bit inj_run, input bit inj_done);
    exp_t e;
    exp_t got;
    logic [W-1:0] acc_m;
    int busy_cycles;
    int done_cycle;
    bit seen;

    acc_m = a;
    for (int i = 0; i < cnt; i++) acc_m = model_step(acc_m, b, f);
    e.res = acc_m;
    e.cnt = CW'(cnt);

    @(negedge clk);
    op = f; opa = a; opb = b; n = CW'(cnt); start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); opa = W'($urandom); opb = W'($urandom); n = CW'($urandom);

    busy_cycles = 0;
    done_cycle  = -1;
    seen        = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        done_cycle = k;
        seen       = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      if (inj_run && k == 1) begin
        start = 1'b1;
        opa   = a ^ 6'h3F;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("done_seen", 32'(seen), 32'd1);

    if (inj_done) begin
      start = 1'b1;
      opa   = a + 6'd7;
      n     = 4'd3;
    end
    got = sb.pop_front();
    checkOutput("result", 32'(result), 32'(got.res));
    checkOutput("iter", 32'(iter), 32'(got.cnt));
    checkOutput("zero", 32'(zero), 32'(got.res == '0));
    checkOutput("done_latency", 32'(done_cycle), 32'(cnt));
    checkOutput("busy_cycles", 32'(busy_cycles), 32'(cnt));

    @(negedge clk);
    start = 1'b0;
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("held_result", 32'(result), 32'(got.res));
    @(negedge clk);
    checkOutput("still_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    start = 1'b0; op = '0; opa = '0; opb = '0; n = '0;
    rstn  = 1'b1;
    #2 rstn = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_zero", 32'(zero), 32'd1);
    checkOutput("rst_iter", 32'(iter), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    $display("[TB] directed command runs");
    applyStimulus(3'd0, 6'd5,  6'd3,  4, 1'b0, 1'b0);
    applyStimulus(3'd1, 6'd2,  6'd3,  1, 1'b0, 1'b0);
    applyStimulus(3'd1, 6'd9,  6'd3,  3, 1'b0, 1'b0);
    applyStimulus(3'd4, 6'h15, 6'h0F, 2, 1'b0, 1'b0);
    applyStimulus(3'd0, 6'h2A, 6'd1,  0, 1'b0, 1'b0);
    applyStimulus(3'd0, 6'd1,  6'd2,  5, 1'b1, 1'b1);
    applyStimulus(3'd6, 6'd7,  6'd3,  2, 1'b0, 1'b0);
    applyStimulus(3'd2, 6'h3C, 6'h27, 15, 1'b0, 1'b0);
    applyStimulus(3'd3, 6'h21, 6'h04, 3, 1'b0, 1'b0);

    $display("[TB] asynchronous reset mid-run");
    @(negedge clk);
    op = 3'd0; opa = 6'd5; opb = 6'd1; n = 4'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_done", 32'(done), 32'd0);
    checkOutput("async_iter", 32'(iter), 32'd0);
    checkOutput("async_result", 32'(result), 32'd0);
    checkOutput("async_zero", 32'(zero), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_idle", 32'(busy), 32'd0);

    applyStimulus(3'd0, 6'd4, 6'd4, 2, 1'b0, 1'b0);

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_alu_seq
